// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB first into a ccff chain; accepts a word only in LOAD (s_ready), shifting starts the next cycle.
// Optional tail readback under CCFF_LOADER_READBACK_EN; no backpressure on the readback strobe.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_start,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [WORD_W-1:0]  sr_q, sr_d;
    logic               last_chain_bit;
    logic               last_word_bit;

    assign last_chain_bit = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign last_word_bit  = (wcnt_q == WCNT_W'(WORD_W - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wcnt_d        = wcnt_q;
        sr_d          = sr_q;
        s_ready       = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        busy          = (state_q != IDLE);
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    sr_d    = s_data;
                    wcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = sr_q[WORD_W-1];
                sr_d          = sr_q << 1;
                cnt_d         = cnt_q + 1'b1;
                wcnt_d        = wcnt_q + 1'b1;
                // Chain end wins over word end: leftover low bits are dropped.
                if (last_chain_bit) begin
                    state_d = DONE;
                end else if (last_word_bit) begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            sr_q    <= sr_d;
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    localparam logic [WORD_W-1:0] RB_MSB = WORD_W'(64'd1 << (WORD_W - 1));

    logic [WORD_W-1:0] rb_sr_q, rb_sr_d;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;

    // Tail bits land left-aligned at the word bit index, so a short final word is zero-padded.
    always_comb begin
        rb_sr_d = rb_sr_q;
        if (ccff_shift_en) begin
            rb_sr_d = (wcnt_q == '0) ? '0 : rb_sr_q;
            if (ccff_tail) begin
                rb_sr_d = rb_sr_d | (RB_MSB >> wcnt_q);
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            rb_sr_q    <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_sr_q    <= rb_sr_d;
            rb_valid_q <= ccff_shift_en && (last_word_bit || last_chain_bit);
            if (ccff_shift_en && (last_word_bit || last_chain_bit)) begin
                rb_data_q <= rb_sr_d;
            end
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_valid    = 1'b0;
    assign rb_data     = '0;
`endif

endmodule
